vga_sync_decoder: RTL

//  Receive-side counterpart of the VGA timing generator: takes a raw hsync/vsync pair and rebuilds

---
 rtl/vga_sync_decoder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: rebuilds hcount/vcount/blanking from raw syncs
// and verifies the incoming timing against the nominal generator before asserting lock.
module vga_sync_decoder #(
   parameter int H_TOTAL       = 1056,
   parameter int H_ACTIVE      = 800,
   parameter int H_SYNC_START  = 840,
   parameter int H_SYNC_END    = 968,
   parameter int V_TOTAL       = 628,
   parameter int V_ACTIVE      = 600,
   parameter int V_SYNC_START  = 601,
   parameter int V_SYNC_END    = 605,
   parameter int LOCK_FRAMES   = 2,
   parameter int ERR_TOLERANCE = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsync_in,
   input  logic        vsync_in,
   output logic [10:0] hcount,
   output logic [10:0] vcount,
   output logic        hsync,
   output logic        vsync,
   output logic        hblnk,
   output logic        vblnk,
   output logic        locked,
   output logic        sync_err
);

   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
   localparam logic [10:0] H_SS   = 11'(H_SYNC_START);
   localparam logic [10:0] H_SE   = 11'(H_SYNC_END);
   localparam logic [10:0] V_SS   = 11'(V_SYNC_START);
   localparam logic [10:0] V_SE   = 11'(V_SYNC_END);
   localparam logic [7:0]  LOCK_C = 8'(LOCK_FRAMES);
   localparam logic [7:0]  TOL_C  = 8'(ERR_TOLERANCE);

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

   state_t      state;
   logic        hs_r, vs_r;
   logic [7:0]  frame_cnt;
   logic [7:0]  err_cnt;
   logic [7:0]  err_cnt_inc;
   logic [10:0] h_next, v_next;
   logic        h_wrap, frame_wrap;
   logic        hs_rise, vs_rise;
   logic        exp_hs, exp_vs, mismatch;

   // Stage 1 captures the raw syncs; stage 2 (hsync/vsync) is aligned with the counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         hs_r  <= 1'b0;
         vs_r  <= 1'b0;
         hsync <= 1'b0;
         vsync <= 1'b0;
      end else begin
         hs_r  <= hsync_in;
         vs_r  <= vsync_in;
         hsync <= hs_r;
         vsync <= vs_r;
      end
   end

   always_comb begin
      h_wrap      = (hcount >= H_LAST);
      frame_wrap  = h_wrap && (vcount >= V_LAST);
      h_next      = h_wrap ? 11'd0 : hcount + 11'd1;
      v_next      = vcount;
      if (h_wrap) begin
         v_next = (vcount >= V_LAST) ? 11'd0 : vcount + 11'd1;
      end
      hs_rise     = hs_r & ~hsync;
      vs_rise     = vs_r & ~vsync;
      exp_hs      = (hcount >= H_SS) && (hcount < H_SE);
      exp_vs      = (vcount >= V_SS) && (vcount < V_SE);
      mismatch    = (hsync != exp_hs) || (vsync != exp_vs);
      err_cnt_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
   end

   // Counters free-run; realignment happens only while searching. A rise is seen on the
   // edge that loads the pulse into hsync/vsync, so the realigned value lands with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         hcount <= 11'd0;
         vcount <= 11'd0;
      end else if (state == SEARCH && vs_rise) begin
         hcount <= 11'd0;
         vcount <= V_SS;
      end else if (state == SEARCH && hs_rise) begin
         hcount <= H_SS;
         vcount <= v_next;
      end else begin
         hcount <= h_next;
         vcount <= v_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SEARCH;
         frame_cnt <= 8'd0;
         err_cnt   <= 8'd0;
         locked    <= 1'b0;
         sync_err  <= 1'b0;
      end else begin
         sync_err <= 1'b0;
         case (state)
            SEARCH: begin
               locked <= 1'b0;
               if (vs_rise) begin
                  state     <= VERIFY;
                  frame_cnt <= 8'd0;
               end
            end
            VERIFY: begin
               if (mismatch) begin
                  sync_err <= 1'b1;
                  state    <= SEARCH;
               end else if (frame_wrap) begin
                  if (frame_cnt + 8'd1 >= LOCK_C) begin
                     state   <= LOCKED;
                     locked  <= 1'b1;
                     err_cnt <= 8'd0;
                  end else begin
                     frame_cnt <= frame_cnt + 8'd1;
                  end
               end
            end
            LOCKED: begin
               if (mismatch) begin
                  sync_err <= 1'b1;
                  if (err_cnt_inc > TOL_C) begin
                     state  <= SEARCH;
                     locked <= 1'b0;
                  end
               end
               // The per-frame error budget restarts at each frame boundary.
               if (frame_wrap) begin
                  err_cnt <= mismatch ? 8'd1 : 8'd0;
               end else if (mismatch) begin
                  err_cnt <= err_cnt_inc;
               end
            end
            default: begin
               state  <= SEARCH;
               locked <= 1'b0;
            end
         endcase
      end
   end

   // Blanking follows the registered counters and is held while timing is unverified.
   assign hblnk = ~locked | (hcount >= H_ACT);
   assign vblnk = ~locked | (vcount >= V_ACT);

endmodule
